// File: rtl/mux_rr_arbiter4.sv
// Round-robin owner arbiter for four requesters sharing one DATA_W-bit channel.
// Define MUX_ARB_TIMEOUT_EN to add the stall counter that forces release of a stuck owner.
module mux_rr_arbiter4 #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_i,
  input  logic [3:0]        last_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] data3_i,
  output logic [3:0]        gnt_o,
  output logic [3:0]        req_ready_o,
  output logic [1:0]        sel_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              timeout_o
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t            state_r;
  logic [3:0]        gnt_r;
  logic [1:0]        sel_r;
  logic [1:0]        last_owner_r;
  logic              timeout_r;
  logic              out_valid_s;
  logic              handshake_s;
  logic              release_s;
  logic              force_s;
  logic [2:0]        pick_idle_s;
  logic [2:0]        pick_rel_s;
  logic [DATA_W-1:0] mux_data_s;

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mux_rr_arbiter4: TIMEOUT must be in 2..255");
  end

  // Returns {found, index} of the first request at base+1, base+2, base+3, base+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) res = {1'b1, idx};
      else          res = res;
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // The released owner is masked out, so it only wins back via IDLE when it is alone.
  assign out_valid_s = ~rst & gnt_r[sel_r] & req_i[sel_r];
  assign handshake_s = out_valid_s & out_ready_i;
  assign release_s   = (handshake_s & last_i[sel_r]) | force_s;
  assign pick_idle_s = rr_pick(req_i, last_owner_r);
  assign pick_rel_s  = rr_pick(req_i & ~gnt_r, sel_r);

  assign gnt_o       = gnt_r;
  assign sel_o       = sel_r;
  assign timeout_o   = timeout_r;
  assign out_valid_o = out_valid_s;
  assign out_last_o  = last_i[sel_r] & out_valid_s;
  assign req_ready_o = gnt_r & {4{out_ready_i & ~rst}};
  assign out_data_o  = mux_data_s;

  // Word mux on the registered owner index, zero while nobody owns the channel.
  always_comb begin
    mux_data_s = {DATA_W{1'b0}};
    if (|gnt_r) begin
      case (sel_r)
        2'd0:    mux_data_s = data0_i;
        2'd1:    mux_data_s = data1_i;
        2'd2:    mux_data_s = data2_i;
        2'd3:    mux_data_s = data3_i;
        default: mux_data_s = {DATA_W{1'b0}};
      endcase
    end else begin
      mux_data_s = {DATA_W{1'b0}};
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] stall_cnt_r;
  logic       stall_phase_r;

  // Stall counter: advances every second OWN cycle, cleared by any beat or ownership change.
  always_ff @(posedge clk) begin
    if (rst || (state_r != OWN) || handshake_s || release_s) begin
      stall_cnt_r   <= 8'd0;
      stall_phase_r <= 1'b0;
    end else begin
      stall_phase_r <= ~stall_phase_r;
      if (stall_phase_r) stall_cnt_r <= stall_cnt_r + 8'd1;
      else               stall_cnt_r <= stall_cnt_r;
    end
  end

  assign force_s = (state_r == OWN) & ~handshake_s & (stall_cnt_r == 8'(TIMEOUT - 1));
`else
  assign force_s = 1'b0;
`endif

  // Ownership FSM: grant registration, release and back-to-back hand-over.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      gnt_r        <= 4'b0000;
      sel_r        <= 2'd0;
      last_owner_r <= 2'd3;
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_idle_s[2]) begin
            gnt_r   <= onehot4(pick_idle_s[1:0]);
            sel_r   <= pick_idle_s[1:0];
            state_r <= OWN;
          end else begin
            gnt_r   <= 4'b0000;
            state_r <= IDLE;
          end
        end
        OWN: begin
          if (release_s) begin
            last_owner_r <= sel_r;
            timeout_r    <= force_s;
            if (pick_rel_s[2]) begin
              gnt_r   <= onehot4(pick_rel_s[1:0]);
              sel_r   <= pick_rel_s[1:0];
              state_r <= OWN;
            end else begin
              gnt_r   <= 4'b0000;
              state_r <= IDLE;
            end
          end else begin
            state_r <= OWN;
          end
        end
        default: begin
          gnt_r   <= 4'b0000;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter4.sv
// Directed bench for mux_rr_arbiter4: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every accepted beat.
module tb_mux_rr_arbiter4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic        ready;
  logic [31:0] dat [4];
  logic [3:0]  gnt;
  logic [3:0]  req_ready;
  logic [1:0]  sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        timeout;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [38:0] exp_q [$];
  logic [38:0] mon_e;

  mux_rr_arbiter4 #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_i(req), .last_i(last),
    .data0_i(dat[0]), .data1_i(dat[1]), .data2_i(dat[2]), .data3_i(dat[3]),
    .gnt_o(gnt), .req_ready_o(req_ready), .sel_o(sel), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_last_o(out_last), .out_ready_i(ready),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [38:0] got, input logic [38:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Expected beat = {req_ready, last, sel, data}
  task automatic push(input logic [1:0] s, input logic [31:0] d, input logic l);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    exp_q.push_back({oh, l, s, d});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1; req = 4'b0000; last = 4'b0000; ready = 1'b0;
    nxt();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    if (out_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL hs_unexpected: got sel=%0d data=%h, expected no handshake", sel, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hs_beat", {req_ready, out_last, sel, out_data}, mon_e);
      end
    end
  end

  initial begin
    logic [1:0] order [5];
    logic [3:0] oh;
    int         bad;
    int         seen;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; req = 4'b0000; last = 4'b0000; ready = 1'b0;
    dat[0] = 32'h1111_0000; dat[1] = 32'h2222_0001;
    dat[2] = 32'h3333_0002; dat[3] = 32'h4444_0003;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt", 39'(gnt), 39'h0);
    chk("rst_sel", 39'(sel), 39'h0);
    chk("rst_timeout", 39'(timeout), 39'h0);
    chk("rst_valid", 39'(out_valid), 39'h0);

    // Single request, single beat
    nxt();
    req = 4'b0001; last = 4'b1111; ready = 1'b1;
    push(2'd0, 32'h1111_0000, 1'b1);
    @(negedge clk);
    chk("t1_latency", 39'(gnt), 39'h0);
    nxt();
    @(negedge clk);
    chk("t1_gnt", 39'(gnt), 39'h1);
    chk("t1_sel", 39'(sel), 39'h0);
    nxt();
    req = 4'b0000;
    @(negedge clk);
    chk("t1_release", 39'(gnt), 39'h0);

    // All requesting, single-beat transfers: 0,1,2,3,0 with no gaps
    do_reset();
    req = 4'b1111; last = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 5; i++) push(order[i], dat[order[i]], 1'b1);
    @(negedge clk);
    chk("t2_pre", 39'(gnt), 39'h0);
    for (int i = 0; i < 5; i++) begin
      nxt();
      @(negedge clk);
      oh = 4'b0001 << order[i];
      chk("t2_sel", 39'(sel), 39'(order[i]));
      chk("t2_gnt", 39'(gnt), 39'(oh));
    end

    // Owner 2, three beats with ready 1,0,1,1; next owner scanned from 3
    do_reset();
    req = 4'b0100; last = 4'b0000; ready = 1'b0; dat[2] = 32'hB000_0001;
    nxt();
    req = 4'b0111; ready = 1'b1;
    push(2'd2, 32'hB000_0001, 1'b0);
    @(negedge clk);
    chk("t3_sel_a", 39'(sel), 39'h2);
    nxt();
    ready = 1'b0; dat[2] = 32'hB000_0002;
    @(negedge clk);
    chk("t3_sel_b", 39'(sel), 39'h2);
    chk("t3_gnt_b", 39'(gnt), 39'h4);
    nxt();
    ready = 1'b1;
    push(2'd2, 32'hB000_0002, 1'b0);
    @(negedge clk);
    chk("t3_sel_c", 39'(sel), 39'h2);
    nxt();
    last = 4'b0100; dat[2] = 32'hB000_0003;
    push(2'd2, 32'hB000_0003, 1'b1);
    @(negedge clk);
    chk("t3_sel_d", 39'(sel), 39'h2);
    nxt();
    req = 4'b0000; last = 4'b0000;
    @(negedge clk);
    chk("t3_next_gnt", 39'(gnt), 39'h1);
    chk("t3_next_sel", 39'(sel), 39'h0);

    // Owner 1 drops its request for two cycles mid-transfer
    do_reset();
    req = 4'b0010; last = 4'b0000; ready = 1'b1; dat[1] = 32'hC000_0001;
    push(2'd1, 32'hC000_0001, 1'b0);
    nxt();
    @(negedge clk);
    chk("t4_gnt", 39'(gnt), 39'h2);
    for (int i = 0; i < 2; i++) begin
      nxt();
      req = 4'b1101;
      @(negedge clk);
      chk("t4_gap_valid", 39'(out_valid), 39'h0);
      chk("t4_gap_gnt", 39'(gnt), 39'h2);
    end
    nxt();
    req = 4'b1111; last = 4'b0010; dat[1] = 32'hC000_0002;
    push(2'd1, 32'hC000_0002, 1'b1);
    @(negedge clk);
    chk("t4_resume_gnt", 39'(gnt), 39'h2);
    nxt();
    req = 4'b0000; last = 4'b0000;
    @(negedge clk);
    chk("t4_next_gnt", 39'(gnt), 39'h4);

    // Reset while owner 1 has a pending beat
    do_reset();
    req = 4'b0010; last = 4'b0000; ready = 1'b0;
    nxt();
    @(negedge clk);
    chk("t5_sel_own", 39'(sel), 39'h1);
    nxt();
    rst = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", 39'(out_valid), 39'h0);
    chk("t5_rst_ready", 39'(req_ready), 39'h0);
    nxt();
    rst = 1'b0; req = 4'b1000; last = 4'b1111; ready = 1'b1;
    push(2'd3, 32'h4444_0003, 1'b1);
    @(negedge clk);
    chk("t5_gnt_after", 39'(gnt), 39'h0);
    chk("t5_sel_after", 39'(sel), 39'h0);
    nxt();
    @(negedge clk);
    chk("t5_gnt3", 39'(gnt), 39'h8);
    chk("t5_sel3", 39'(sel), 39'h3);
    nxt();
    req = 4'b0000;
    @(negedge clk);
    chk("t5_release", 39'(gnt), 39'h0);

    // Sole requester is re-granted through one idle bubble
    do_reset();
    req = 4'b0001; last = 4'b1111; ready = 1'b1;
    push(2'd0, 32'h1111_0000, 1'b1);
    push(2'd0, 32'h1111_0000, 1'b1);
    nxt();
    @(negedge clk);
    chk("t7_gnt_a", 39'(gnt), 39'h1);
    nxt();
    @(negedge clk);
    chk("t7_bubble", 39'(gnt), 39'h0);
    nxt();
    @(negedge clk);
    chk("t7_gnt_b", 39'(gnt), 39'h1);
    nxt();
    req = 4'b0000;
    @(negedge clk);
    chk("t7_release", 39'(gnt), 39'h0);

    // Stalled owner 0 with requester 1 waiting
    do_reset();
    req = 4'b0011; last = 4'b0000; ready = 1'b0;
    nxt();
    @(negedge clk);
    chk("t6_gnt", 39'(gnt), 39'h1);
`ifdef MUX_ARB_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      nxt();
      @(negedge clk);
      if (timeout) seen = 1;
    end
    chk("t6_timeout_seen", 39'(seen), 39'h1);
    chk("t6_timeout_gnt", 39'(gnt), 39'h2);
    nxt();
    @(negedge clk);
    chk("t6_timeout_pulse", 39'(timeout), 39'h0);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      nxt();
      @(negedge clk);
      if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
    end
    chk("t6_hold", 39'(bad), 39'h0);
`endif
    do_reset();
    @(negedge clk);
    chk("sb_drain", 39'(exp_q.size()), 39'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
